// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared constants and read-source selection for the write-back register file
`ifndef WB_REGFILE_DEFINES
`define WB_REGFILE_DEFINES
`define RegBus       31:0
`define RegAddrBus   4:0
`define RegNum       32
`define NOPRegAddr   '0
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define ZeroWord     '0
`define RstnEnable   1'b0
`endif

package wb_regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = `RegNum;

    // Where a read port takes its data from
    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_BYPASS = 2'd1,
        RD_ARRAY  = 2'd2
    } rd_src_e;

    // Read-port priority: reset, disabled port and r0 all give zero; a pending
    // WB write to the same register beats the (stale) array contents.
    function automatic rd_src_e rd_src(input logic in_reset, input logic re,
                                       input logic addr_zero, input logic wb_hit);
        if (in_reset || !re || addr_zero) return RD_ZERO;
        if (wb_hit)                       return RD_BYPASS;
        return RD_ARRAY;
    endfunction

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// rtl/wb_regfile_regfile_2r1w.sv - GPR array, one synchronous write port, two asynchronous read ports
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic waddr_ok;
    logic raddr1_ok;
    logic raddr2_ok;

    // r0 is never written; addresses past the array are ignored on write and read as zero
    assign waddr_ok  = (waddr  != `NOPRegAddr) && (int'(waddr)  < NUM_REGS);
    assign raddr1_ok = (raddr1 != `NOPRegAddr) && (int'(raddr1) < NUM_REGS);
    assign raddr2_ok = (raddr2 != `NOPRegAddr) && (int'(raddr2) < NUM_REGS);

    // Whole array clears on reset; otherwise a single committed write per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RstnEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= `ZeroWord;
            end
        end else if (we == `WriteEnable && waddr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous reads
    always_comb begin
        rdata1 = `ZeroWord;
        rdata2 = `ZeroWord;
        if (raddr1_ok) rdata1 = regs[raddr1];
        if (raddr2_ok) rdata2 = regs[raddr2];
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB pipeline latch, GPR commit and ID-stage read ports with WB bypass
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    logic [DATA_W-1:0] arr_rdata1;
    logic [DATA_W-1:0] arr_rdata2;
    logic              in_reset;
    logic              wb_live;
    rd_src_e           src1;
    rd_src_e           src2;

    // MEM/WB latch: flush beats stall, both insert a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RstnEnable) begin
            wb_wd_o    <= `NOPRegAddr;
            wb_wreg_o  <= `WriteDisable;
            wb_wdata_o <= `ZeroWord;
        end else if (flush_i || stall_i) begin
            wb_wd_o    <= `NOPRegAddr;
            wb_wreg_o  <= `WriteDisable;
            wb_wdata_o <= `ZeroWord;
        end else begin
            wb_wd_o    <= wd_i;
            wb_wreg_o  <= wreg_i;
            wb_wdata_o <= wdata_i;
        end
    end

    // The latched WB triple commits on the next edge regardless of stall/flush
    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_gpr (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_wreg_o),
        .waddr  (wb_wd_o),
        .wdata  (wb_wdata_o),
        .raddr1 (raddr1_i),
        .rdata1 (arr_rdata1),
        .raddr2 (raddr2_i),
        .rdata2 (arr_rdata2)
    );

    assign in_reset = (rst == `RstnEnable);
    assign wb_live  = (wb_wreg_o == `WriteEnable);
    assign src1 = rd_src(in_reset, re1_i, raddr1_i == `NOPRegAddr, wb_live && (wb_wd_o == raddr1_i));
    assign src2 = rd_src(in_reset, re2_i, raddr2_i == `NOPRegAddr, wb_live && (wb_wd_o == raddr2_i));

    // Read-port muxes: zero, pending write-back, or array contents
    always_comb begin
        rdata1_o = `ZeroWord;
        rdata2_o = `ZeroWord;
        case (src1)
            RD_BYPASS: rdata1_o = wb_wdata_o;
            RD_ARRAY:  rdata1_o = arr_rdata1;
            default:   rdata1_o = `ZeroWord;
        endcase
        case (src2)
            RD_BYPASS: rdata2_o = wb_wdata_o;
            RD_ARRAY:  rdata2_o = arr_rdata2;
            default:   rdata2_o = `ZeroWord;
        endcase
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .wb_wdata_o (wb_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;

    logic [31:0] m_regs [32];
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'h0;
        if (m_wreg && m_wd == a) return m_wdata;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_wd = 5'd0;
        m_wreg = 1'b0;
        m_wdata = 32'h0;
    endtask

    // Reference behaviour at a rising edge, using the inputs currently driven
    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else begin
            if (m_wreg && m_wd != 5'd0) m_regs[m_wd] = m_wdata;
            if (flush_i || stall_i) begin
                m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'h0;
            end else begin
                m_wd = wd_i; m_wreg = wreg_i; m_wdata = wdata_i;
            end
        end
    endtask

    // Entered just after a rising edge: drive, predict, compare mid-cycle, then clock
    task automatic step(input logic st, input logic fl, input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdat, input logic r1e, input logic [4:0] a1,
                        input logic r2e, input logic [4:0] a2, input string tag);
        exp_t e;
        stall_i = st; flush_i = fl; wd_i = wd; wreg_i = wr; wdata_i = wdat;
        re1_i = r1e; raddr1_i = a1; re2_i = r2e; raddr2_i = a2;
        e.r1 = m_read(r1e, a1);
        e.r2 = m_read(r2e, a2);
        e.wd = m_wd;
        e.wreg = m_wreg;
        e.wdata = m_wdata;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".rdata1"}, rdata1_o, e.r1);
        check({tag, ".rdata2"}, rdata2_o, e.r2);
        check({tag, ".wb_wd"}, {27'h0, wb_wd_o}, {27'h0, e.wd});
        check({tag, ".wb_wreg"}, {31'h0, wb_wreg_o}, {31'h0, e.wreg});
        check({tag, ".wb_wdata"}, wb_wdata_o, e.wdata);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, a1, 1'b1, a2, tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        re1_i = 1'b0; raddr1_i = 5'd0; re2_i = 1'b0; raddr2_i = 5'd0;
        model_reset();
        @(posedge clk);
        #1;

        // Held in reset with an active write request
        step(1'b0, 1'b0, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b1, 5'd5, "rst_hold0");
        step(1'b0, 1'b0, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b1, 5'd5, "rst_hold1");
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        // inputs still show the r5 write at that first edge out of reset
        m_wd = 5'd5; m_wreg = 1'b1; m_wdata = 32'hDEAD_BEEF;
        m_regs[5] = 32'h0;
        idle_read(5'd5, 5'd5, "post_rst_bypass");
        model_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        idle_read(5'd5, 5'd5, "gpr5_clear");

        // Basic write, bypass then array
        step(1'b0, 1'b0, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 5'd3, 1'b0, 5'd3, "basic_w");
        idle_read(5'd3, 5'd3, "basic_bypass");
        idle_read(5'd3, 5'd3, "basic_array");

        // r0 writes are dropped
        step(1'b0, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, "r0_w");
        idle_read(5'd0, 5'd0, "r0_rd0");
        idle_read(5'd0, 5'd3, "r0_rd1");

        // Stall bubbles the r7 write
        step(1'b1, 1'b0, 5'd7, 1'b1, 32'h7777_7777, 1'b1, 5'd7, 1'b1, 5'd7, "stall_w");
        idle_read(5'd7, 5'd7, "stall_rd0");
        idle_read(5'd7, 5'd7, "stall_rd1");

        // Flush+stall while r9 is in WB: r9 commits, r10 is dropped
        step(1'b0, 1'b0, 5'd9, 1'b1, 32'h9999_0009, 1'b1, 5'd9, 1'b1, 5'd10, "r9_w");
        step(1'b1, 1'b1, 5'd10, 1'b1, 32'hAAAA_000A, 1'b1, 5'd9, 1'b1, 5'd10, "flush");
        idle_read(5'd9, 5'd10, "flush_rd");

        // Back-to-back writes to r4
        step(1'b0, 1'b0, 5'd4, 1'b1, 32'h1, 1'b1, 5'd4, 1'b1, 5'd4, "b2b_w1");
        step(1'b0, 1'b0, 5'd4, 1'b1, 32'h2, 1'b1, 5'd4, 1'b1, 5'd4, "b2b_w2");
        idle_read(5'd4, 5'd4, "b2b_rd0");
        idle_read(5'd4, 5'd4, "b2b_rd1");

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), "rand");
        end

        // Asynchronous reset with r6 pending in WB
        step(1'b0, 1'b0, 5'd6, 1'b1, 32'h6666_6666, 1'b1, 5'd6, 1'b1, 5'd6, "r6_w");
        wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_rst.wb_wreg", {31'h0, wb_wreg_o}, 32'h0);
        check("async_rst.wb_wd", {27'h0, wb_wd_o}, 32'h0);
        check("async_rst.wb_wdata", wb_wdata_o, 32'h0);
        check("async_rst.rdata1", rdata1_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        idle_read(5'd6, 5'd6, "async_rst_gpr6");
        idle_read(5'd3, 5'd4, "async_rst_others");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
